// File: rtl/branch_predict_tournament.sv
// Tournament branch predictor: a per-PC local-history predictor and a
// global-history predictor, arbitrated per branch by a 2-bit chooser table.
// The prediction is looked up in F and registered into D. Training happens
// in M. After reset a sequential sweep initialises every table, so the
// arrays themselves carry no reset.
module branch_predict_tournament #(
    parameter int BHT_DEPTH = 10,
    parameter int LHR_WIDTH = 6,
    parameter int GHR_WIDTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flushD,
    input  logic        stallD,
    input  logic [31:0] pcF,
    input  logic [31:0] pcM,
    input  logic        branchM,
    input  logic        actual_takeM,
    input  logic        branchD,
    output logic        pred_takeD,
    output logic        pred_srcD,
    output logic        readyF,
    output logic [31:0] mispred_cnt
);

    localparam int IW_BL   = (BHT_DEPTH > LHR_WIDTH) ? BHT_DEPTH : LHR_WIDTH;
    localparam int IW      = (IW_BL > GHR_WIDTH) ? IW_BL : GHR_WIDTH;
    localparam int NSLICES = (30 + BHT_DEPTH - 1) / BHT_DEPTH;

    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    // XOR-fold of pc[31:2] into BHT_DEPTH bits; the last slice is zero-extended.
    function automatic logic [BHT_DEPTH-1:0] pcHash(input logic [31:0] pc);
        logic [29:0]          rem;
        logic [BHT_DEPTH-1:0] h;
        h   = '0;
        rem = pc[31:2];
        for (int s = 0; s < NSLICES; s++) begin
            h   = h ^ rem[BHT_DEPTH-1:0];
            rem = rem >> BHT_DEPTH;
        end
        return h;
    endfunction

    // One step of a 2-bit saturating counter toward taken (up=1) or not-taken.
    function automatic logic [1:0] satStep(input logic [1:0] c, input logic up);
        logic [1:0] n;
        if (up) begin
            n = (c == 2'b11) ? c : c + 2'd1;
        end else begin
            n = (c == 2'b00) ? c : c - 2'd1;
        end
        return n;
    endfunction

    logic [LHR_WIDTH-1:0] lht     [2**BHT_DEPTH];
    logic [1:0]           lpht    [2**LHR_WIDTH];
    logic [1:0]           gpht    [2**GHR_WIDTH];
    logic [1:0]           chooser [2**GHR_WIDTH];

    state_t               stateR, stateS;
    logic [IW-1:0]        kR;
    logic                 readyR;
    logic [GHR_WIDTH-1:0] ghrR;
    logic [31:0]          misCntR;
    logic                 predR, srcR;

    logic [BHT_DEPTH-1:0] hashF, hashM;
    logic [LHR_WIDTH-1:0] lIdxF, lIdxM, lhtM;
    logic [GHR_WIDTH-1:0] gIdxF, gIdxM, cIdxF, cIdxM;
    logic                 predF, srcF, useGlobF;
    logic                 lpM, gpM, finalM, trainS;
    logic [1:0]           chM, chNextM, lphtNextM, gphtNextM;
    logic                 unusedPcBits;

    assign unusedPcBits = ^{pcF[1:0], pcM[1:0]};

    // Next-state logic: sweep until the last index is written, then run forever.
    always_comb begin
        stateS = stateR;
        case (stateR)
            INIT: begin
                if (kR == {IW{1'b1}}) begin
                    stateS = RUN;
                end else begin
                    stateS = INIT;
                end
            end
            RUN:     stateS = RUN;
            default: stateS = INIT;
        endcase
    end

    // FSM state, sweep index and ready flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stateR <= INIT;
            kR     <= '0;
            readyR <= 1'b0;
        end else begin
            stateR <= stateS;
            readyR <= (stateS == RUN);
            if (stateR == INIT) begin
                kR <= kR + IW'(1);
            end
        end
    end

    // F-stage lookup; forced to "local, not taken" until the tables are valid.
    always_comb begin
        hashF    = pcHash(pcF);
        lIdxF    = lht[hashF] ^ hashF[LHR_WIDTH-1:0];
        cIdxF    = pcF[GHR_WIDTH+1:2];
        gIdxF    = ghrR ^ cIdxF;
        useGlobF = chooser[cIdxF][1];
        predF    = 1'b0;
        srcF     = 1'b0;
        if (readyR) begin
            predF = useGlobF ? gpht[gIdxF][1] : lpht[lIdxF][1];
            srcF  = useGlobF;
        end else begin
            predF = 1'b0;
            srcF  = 1'b0;
        end
    end

    // M-stage recompute of the prediction and the next table values.
    always_comb begin
        trainS    = (stateR == RUN) && branchM;
        hashM     = pcHash(pcM);
        lhtM      = lht[hashM];
        lIdxM     = lhtM ^ hashM[LHR_WIDTH-1:0];
        cIdxM     = pcM[GHR_WIDTH+1:2];
        gIdxM     = ghrR ^ cIdxM;
        chM       = chooser[cIdxM];
        lpM       = lpht[lIdxM][1];
        gpM       = gpht[gIdxM][1];
        finalM    = chM[1] ? gpM : lpM;
        lphtNextM = satStep(lpht[lIdxM], actual_takeM);
        gphtNextM = satStep(gpht[gIdxM], actual_takeM);
        if ((lpM == actual_takeM) && (gpM != actual_takeM)) begin
            chNextM = satStep(chM, 1'b0);
        end else if ((gpM == actual_takeM) && (lpM != actual_takeM)) begin
            chNextM = satStep(chM, 1'b1);
        end else begin
            chNextM = chM;
        end
    end

    // Table writes: init sweep, or training of the M branch. No reset on arrays.
    always_ff @(posedge clk) begin
        if (stateR == INIT) begin
            lht[kR[BHT_DEPTH-1:0]]     <= '0;
            lpht[kR[LHR_WIDTH-1:0]]    <= 2'b10;
            gpht[kR[GHR_WIDTH-1:0]]    <= 2'b10;
            chooser[kR[GHR_WIDTH-1:0]] <= 2'b01;
        end else if (trainS) begin
            lpht[lIdxM]    <= lphtNextM;
            gpht[gIdxM]    <= gphtNextM;
            lht[hashM]     <= {lhtM[LHR_WIDTH-2:0], actual_takeM};
            chooser[cIdxM] <= chNextM;
        end
    end

    // Global history shift and misprediction counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ghrR    <= '0;
            misCntR <= 32'd0;
        end else if (trainS) begin
            ghrR <= {ghrR[GHR_WIDTH-2:0], actual_takeM};
            if (finalM != actual_takeM) begin
                misCntR <= misCntR + 32'd1;
            end
        end
    end

    // F->D prediction register; flush has priority over stall.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            predR <= 1'b0;
            srcR  <= 1'b0;
        end else if (flushD) begin
            predR <= 1'b0;
            srcR  <= 1'b0;
        end else if (!stallD) begin
            predR <= predF;
            srcR  <= srcF;
        end
    end

    assign pred_takeD  = branchD & predR;
    assign pred_srcD   = srcR;
    assign readyF      = readyR;
    assign mispred_cnt = misCntR;

endmodule
